// File: rtl/main_path_sched.sv
// main_path_sched: sequences main-path passes per layer, waits on done with a watchdog,
// then streams the result BRAM back with a one-cycle-latency writeback tag.
module main_path_sched #(
  parameter int NUM_LAYERS = 4,
  parameter int IMG_W = 5,
  parameter int IMG_H = 4,
  parameter int FM_ADDR_W = 10,
  parameter int KSEL_W = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clk_en,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_mp_start,
  input  logic                 i_mp_done,
  output logic [KSEL_W-1:0]    o_kernel_sel,
  output logic [FM_ADDR_W-1:0] o_bram_rd_addr,
  output logic                 o_wb_valid,
  output logic [KSEL_W-1:0]    o_wb_layer,
  output logic                 o_wb_last
);
  localparam int PIXEL_COUNT = IMG_W * IMG_H;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT, READBACK, NEXT, DONE, ERR} state_t;
  state_t state, state_n;
  logic [KSEL_W-1:0] layer;
  logic [FM_ADDR_W-1:0] pix;
  logic [WD_W-1:0] wd;
  logic pix_last, layer_last, wd_exp;
  assign pix_last = pix == FM_ADDR_W'(PIXEL_COUNT - 1);
  assign layer_last = layer == KSEL_W'(NUM_LAYERS - 1);
  assign wd_exp = wd == WD_W'(TIMEOUT - 1);
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  assign o_kernel_sel = layer;
  assign o_bram_rd_addr = pix;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = i_start ? WAIT : IDLE;
      WAIT:     state_n = i_mp_done ? READBACK : wd_exp ? ERR : WAIT;
      READBACK: state_n = pix_last ? NEXT : READBACK;
      NEXT:     state_n = layer_last ? DONE : WAIT;
      DONE:     state_n = IDLE;
      ERR:      state_n = ERR;
      default:  state_n = IDLE;
    endcase
    if (i_abort) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      layer <= '0;
      pix <= '0;
      wd <= '0;
      o_mp_start <= 1'b0;
      o_err <= 1'b0;
      o_wb_valid <= 1'b0;
      o_wb_layer <= '0;
      o_wb_last <= 1'b0;
    end else if (i_clk_en) begin
      state <= state_n;
      // a start pulse accompanies every entry into WAIT, from IDLE or NEXT
      o_mp_start <= state_n == WAIT && state != WAIT;
      wd <= (state == WAIT && state_n == WAIT) ? wd + 1'b1 : '0;
      pix <= (state == READBACK && state_n == READBACK) ? pix + 1'b1 : '0;
      layer <= (state == NEXT && state_n == WAIT) ? layer + 1'b1 :
               (state == IDLE || state_n == IDLE) ? '0 : layer;
      o_err <= state_n == ERR;
      o_wb_valid <= state == READBACK && !i_abort;
      o_wb_layer <= layer;
      o_wb_last <= state == READBACK && pix_last && layer_last && !i_abort;
    end
  end
endmodule

// File: tb/tb_main_path_sched.sv
// tb_main_path_sched: directed checks of job sequencing, readback stream, watchdog, clock enable and abort/reset.
module tb_main_path_sched;
  logic clk = 0, rst_n = 0, i_clk_en = 1, i_start = 0, i_abort = 0, i_mp_done = 0;
  logic o_busy, o_done, o_err, o_mp_start, o_wb_valid, o_wb_last;
  logic [1:0] o_kernel_sel, o_wb_layer;
  logic [9:0] o_bram_rd_addr, bram_q;
  int checks = 0, errors = 0;
  int n_start, beats, n_done, lasts, exp_addr, exp_layer, cd;
  bit auto_done;

  main_path_sched #(.NUM_LAYERS(2), .IMG_W(5), .IMG_H(4), .FM_ADDR_W(10), .KSEL_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .i_clk_en(i_clk_en), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_mp_start(o_mp_start), .i_mp_done(i_mp_done),
    .o_kernel_sel(o_kernel_sel), .o_bram_rd_addr(o_bram_rd_addr), .o_wb_valid(o_wb_valid),
    .o_wb_layer(o_wb_layer), .o_wb_last(o_wb_last));

  always #5 clk = ~clk;
  // result BRAM stand-in: read data is the address issued one enabled cycle earlier
  always @(posedge clk) if (i_clk_en) bram_q <= o_bram_rd_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_start = 0; beats = 0; n_done = 0; lasts = 0; exp_addr = 0; exp_layer = 0; cd = 0;
  endtask

  task automatic cyc();
    logic en;
    logic [9:0] a0;
    logic v0;
    en = i_clk_en; a0 = o_bram_rd_addr; v0 = o_wb_valid;
    @(posedge clk); #1;
    if (!en) begin
      chk("hold_addr", o_bram_rd_addr, a0);
      chk("hold_valid", o_wb_valid, v0);
      return;
    end
    i_start = 0; i_abort = 0; i_mp_done = 0;
    if (o_mp_start) begin
      n_start++;
      chk("ksel_at_start", o_kernel_sel, n_start - 1);
      cd = 10;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0 && auto_done) i_mp_done = 1;
    end
    if (o_wb_valid) begin
      chk("wb_addr", bram_q, exp_addr);
      chk("wb_layer", o_wb_layer, exp_layer);
      chk("wb_last", o_wb_last, exp_addr == 19 && exp_layer == 1);
      if (o_wb_last) lasts++;
      beats++;
      exp_addr = exp_addr == 19 ? 0 : exp_addr + 1;
      if (exp_addr == 0) exp_layer++;
    end
    if (o_done) n_done++;
  endtask

  task automatic run_job(input string tag);
    int k;
    k = 0;
    while (n_done == 0 && k < 400) begin cyc(); k++; end
    chk({tag, "_done_seen"}, n_done, 1);
    repeat (5) cyc();
    chk({tag, "_starts"}, n_start, 2);
    chk({tag, "_beats"}, beats, 40);
    chk({tag, "_lasts"}, lasts, 1);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_mps"}, o_mp_start, 0);
    chk({tag, "_wbv"}, o_wb_valid, 0);
    chk({tag, "_wbl"}, o_wb_last, 0);
    chk({tag, "_ksel"}, o_kernel_sel, 0);
    chk({tag, "_wblay"}, o_wb_layer, 0);
    chk({tag, "_addr"}, o_bram_rd_addr, 0);
  endtask

  initial begin
    int k;
    bit inj_s, inj_d;
    clr(); auto_done = 1;
    #12;
    chk_reset_outs("reset");
    @(posedge clk); #1 rst_n = 1;
    cyc();

    // nominal two-layer job
    clr(); i_start = 1; run_job("nominal");

    // start during WAIT and done during READBACK are ignored
    clr(); inj_s = 0; inj_d = 0; i_start = 1; k = 0;
    while (n_done == 0 && k < 400) begin
      cyc(); k++;
      if (n_start == 1 && !inj_s) begin i_start = 1; inj_s = 1; end
      if (beats == 5 && !inj_d) begin i_mp_done = 1; inj_d = 1; end
    end
    run_job("ignored");

    // clock enable toggled 1010 during readback
    clr(); i_start = 1; k = 0;
    while (n_done == 0 && k < 400) begin
      cyc(); k++;
      i_clk_en = (beats >= 3 && beats < 13) ? ~i_clk_en : 1'b1;
    end
    i_clk_en = 1;
    run_job("clken");

    // watchdog timeout
    clr(); auto_done = 0; i_start = 1; k = 0;
    while (n_start == 0 && k < 10) begin cyc(); k++; end
    chk("to_mp_start", n_start, 1);
    k = 0;
    while (!o_err && k < 100) begin cyc(); k++; end
    chk("to_latency", k, 64);
    chk("to_busy", o_busy, 1);
    repeat (10) cyc();
    chk("to_err_sticky", o_err, 1);
    chk("to_busy_hold", o_busy, 1);
    chk("to_no_beats", beats, 0);
    chk("to_no_restart", n_start, 1);
    i_abort = 1; cyc();
    chk("to_abort_busy", o_busy, 0);
    chk("to_abort_err", o_err, 0);
    auto_done = 1;

    // abort at readback address 7
    clr(); i_start = 1; k = 0;
    while (o_bram_rd_addr != 7 && k < 100) begin cyc(); k++; end
    chk("ab_reach7", o_bram_rd_addr, 7);
    i_abort = 1; cyc();
    chk("ab_wbv", o_wb_valid, 0);
    chk("ab_busy", o_busy, 0);
    repeat (20) cyc();
    chk("ab_no_done", n_done, 0);
    clr(); i_start = 1; run_job("ab_restart");

    // asynchronous reset at readback address 7
    clr(); i_start = 1; k = 0;
    while (o_bram_rd_addr != 7 && k < 100) begin cyc(); k++; end
    chk("rs_reach7", o_bram_rd_addr, 7);
    rst_n = 0; #1;
    chk_reset_outs("midreset");
    @(posedge clk); #1 rst_n = 1;
    repeat (30) cyc();
    chk("rs_no_done", n_done, 0);
    chk("rs_idle", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
